retire_trace_buffer: RTL and testbench
======================================

Name: retire_trace_buffer

Overview:
- Sits directly downstream of the core's retirement outputs.
- Each cycle, captures up to IssueWidth=2 retired-instruction packets.
- Tags each packet with a monotonically increasing retire sequence number, buffers it in a FIFO, and emits packets one per cycle on a valid/ready trace stream.
- The stream feeds the verification/grading logger and the debug trace port. Overflow is detected, counted and flagged, never silently lost.

Parameters:
- XLEN, 32, data/address width of retired fields.
- IssueWidth, 2, retire lanes per cycle; only the value 2 is supported.
- Depth, 16, FIFO entries; power of 2, at least 4.
- SeqWidth, 32, width of the sequence number and drop counter.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush: empties the FIFO and zeroes the sequence counter, drop counter and overflow flag
- update_i  in  1 x IssueWidth  retire valid per lane
- pc_i  in  XLEN x IssueWidth  retired PC
- instr_i  in  XLEN x IssueWidth  retired instruction
- reg_addr_i  in  5 x IssueWidth  retired rd
- reg_data_i  in  XLEN x IssueWidth  retired rd data
- mem_addr_i  in  XLEN x IssueWidth  retired memory address
- mem_data_i  in  XLEN x IssueWidth  retired memory data
- mem_wrt_i  in  1 x IssueWidth  retired store flag
- trace_valid_o  out  1  head entry available
- trace_ready_i  in  1  consumer accepts head
- trace_seq_o  out  SeqWidth  sequence number of head
- trace_pc_o, trace_instr_o, trace_reg_addr_o, trace_reg_data_o, trace_mem_addr_o, trace_mem_data_o, trace_mem_wrt_o  out  widths as inputs  head packet fields
- count_o  out  clog2(Depth)+1  current occupancy
- overflow_o  out  1  sticky: at least one packet dropped since reset/clear
- drop_count_o  out  SeqWidth  total packets dropped

Behaviour:
- Reset (async, rstn_i=0): FIFO empty; all outputs are 0, including trace_valid_o, count_o, overflow_o, drop_count_o and every trace_* field. Sequence counter is 0.
- Enqueue, per cycle:
  - n = update_i[0] + update_i[1].
  - Lane 0 is always ordered before lane 1.
  - If only update_i[1] is set, the lane-1 packet is compacted to a single push.
- Admission is atomic per cycle. Free slots are computed as Depth - count_o using the registered count before this cycle's pop; a same-cycle pop does not add space.
  - If free >= n, all n packets are written.
  - Otherwise none are written, overflow_o is set sticky, and drop_count_o increments by n, saturating at all-ones.
- Sequence numbers:
  - The first accepted-or-dropped packet gets the current counter value S; the second gets S+1.
  - The counter advances by n whether the packets are accepted or dropped, so drops appear as gaps in trace_seq_o.
  - Arithmetic is modulo 2^SeqWidth; wrap from all-ones to 0 is silent.
- Dequeue: first-word-fall-through.
  - trace_valid_o = (count != 0). trace_* fields show the head entry combinationally from the storage array; fields are 0 when empty.
  - A pop occurs when trace_valid_o && trace_ready_i.
  - trace_* must remain stable while valid && !ready.
- Latency: a packet retired in cycle t is visible at the head no earlier than cycle t+1. With an empty FIFO and ready=1, lane 0 appears at t+1 and lane 1 at t+2.
- Simultaneous push and pop: count_next = count + pushed - popped. Pointers wrap modulo Depth.
- clear_i has priority over push and pop in the same cycle. Inputs presented that cycle are discarded and are not counted as drops. The sequence counter becomes 0.
- Async reset asserted mid-stream discards all contents immediately; trace_valid_o drops in the same cycle.
- reg_addr 0 and mem_wrt=0 packets are stored verbatim, with no filtering.

Test Plan:
1. Reset then single push: update_i={1,0}, pc_i[0]=0x80000000. Next cycle: trace_valid_o=1, trace_pc_o=0x80000000, trace_seq_o=0, count_o=1.
2. Dual push with ready=1: lane0 pc=0x100, lane1 pc=0x104. Output order is 0x100 (seq 0) then 0x104 (seq 1) on consecutive cycles; count_o returns to 0.
3. Lane-1-only push: update_i={0,1}, pc=0x200. Exactly one entry with pc=0x200 and seq 0; count_o=1.
4. Overflow: ready=0, Depth=16, fill to 15, then dual push. Nothing written; count_o=15, overflow_o=1, drop_count_o=2. The next single push gets seq 17.
5. Backpressure stability: 3 entries queued, ready=0 for 5 cycles. trace_* unchanged. Then ready=1 drains 3 entries in 3 cycles in sequence order.
6. Clear during simultaneous push/pop: count=4, clear_i=1 together with update_i={1,1} and ready=1. Next cycle: count_o=0, trace_valid_o=0, overflow_o=0, drop_count_o=0. The next push gets seq 0.

Source files
------------

// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - dual-lane retirement capture, sequence tagging and FWFT trace FIFO
module retire_trace_buffer #(
  parameter int XLEN       = 32,
  parameter int IssueWidth = 2,
  parameter int Depth      = 16,
  parameter int SeqWidth   = 32
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                clear_i,
  input  logic [IssueWidth-1:0]               update_i,
  input  logic [IssueWidth-1:0][XLEN-1:0]     pc_i,
  input  logic [IssueWidth-1:0][XLEN-1:0]     instr_i,
  input  logic [IssueWidth-1:0][4:0]          reg_addr_i,
  input  logic [IssueWidth-1:0][XLEN-1:0]     reg_data_i,
  input  logic [IssueWidth-1:0][XLEN-1:0]     mem_addr_i,
  input  logic [IssueWidth-1:0][XLEN-1:0]     mem_data_i,
  input  logic [IssueWidth-1:0]               mem_wrt_i,
  output logic                                trace_valid_o,
  input  logic                                trace_ready_i,
  output logic [SeqWidth-1:0]                 trace_seq_o,
  output logic [XLEN-1:0]                     trace_pc_o,
  output logic [XLEN-1:0]                     trace_instr_o,
  output logic [4:0]                          trace_reg_addr_o,
  output logic [XLEN-1:0]                     trace_reg_data_o,
  output logic [XLEN-1:0]                     trace_mem_addr_o,
  output logic [XLEN-1:0]                     trace_mem_data_o,
  output logic                                trace_mem_wrt_o,
  output logic [$clog2(Depth):0]              count_o,
  output logic                                overflow_o,
  output logic [SeqWidth-1:0]                 drop_count_o
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(Depth);

  typedef struct packed {
    logic [SeqWidth-1:0] seq;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     instr;
    logic [4:0]          reg_addr;
    logic [XLEN-1:0]     reg_data;
    logic [XLEN-1:0]     mem_addr;
    logic [XLEN-1:0]     mem_data;
    logic                mem_wrt;
  } entry_t;

  entry_t              mem_q [Depth];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q;
  logic [SeqWidth-1:0] seq_q;
  logic                overflow_q;
  logic [SeqWidth-1:0] drop_q;

  logic [1:0]          n;
  logic [AW:0]         n_ext, free, pushed;
  logic                accept, do_push, pop;
  logic [AW-1:0]       wr_ptr_p1;
  logic [SeqWidth:0]   drop_sum;
  logic [SeqWidth-1:0] drop_nx;
  entry_t              first_e, second_e, head;

  function automatic entry_t mk_entry(input int lane, input logic [SeqWidth-1:0] seq);
    entry_t e;
    e.seq      = seq;
    e.pc       = pc_i[lane];
    e.instr    = instr_i[lane];
    e.reg_addr = reg_addr_i[lane];
    e.reg_data = reg_data_i[lane];
    e.mem_addr = mem_addr_i[lane];
    e.mem_data = mem_data_i[lane];
    e.mem_wrt  = mem_wrt_i[lane];
    return e;
  endfunction

  assign n       = {1'b0, update_i[0]} + {1'b0, update_i[1]};
  assign n_ext   = {{(AW-1){1'b0}}, n};
  // Free space uses the pre-pop count so a drain in the same cycle never admits extra packets.
  assign free    = DEPTH_L - count_q;
  assign accept  = (n_ext <= free);
  assign do_push = accept && (n != 2'd0);
  assign pushed  = accept ? n_ext : '0;
  assign pop     = trace_valid_o && trace_ready_i;

  assign wr_ptr_p1 = wr_ptr_q + AW'(1);
  assign drop_sum  = {1'b0, drop_q} + (SeqWidth+1)'(n);
  assign drop_nx   = drop_sum[SeqWidth] ? '1 : drop_sum[SeqWidth-1:0];

  // A lone lane-1 packet is compacted into the first slot with the first sequence number.
  always_comb begin
    first_e  = update_i[0] ? mk_entry(0, seq_q) : mk_entry(1, seq_q);
    second_e = mk_entry(1, seq_q + SeqWidth'(1));
  end

  always_ff @(posedge clk_i) begin
    if (!clear_i && do_push) begin
      mem_q[wr_ptr_q] <= first_e;
      if (n == 2'd2) mem_q[wr_ptr_p1] <= second_e;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (clear_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(n);
      count_q <= count_q + pushed - (AW+1)'(pop);
      seq_q   <= seq_q + SeqWidth'(n);
      if (!accept) begin
        overflow_q <= 1'b1;
        drop_q     <= drop_nx;
      end
    end
  end

  assign trace_valid_o    = (count_q != '0);
  assign head             = trace_valid_o ? mem_q[rd_ptr_q] : '0;
  assign trace_seq_o      = head.seq;
  assign trace_pc_o       = head.pc;
  assign trace_instr_o    = head.instr;
  assign trace_reg_addr_o = head.reg_addr;
  assign trace_reg_data_o = head.reg_data;
  assign trace_mem_addr_o = head.mem_addr;
  assign trace_mem_data_o = head.mem_data;
  assign trace_mem_wrt_o  = head.mem_wrt;
  assign count_o          = count_q;
  assign overflow_o       = overflow_q;
  assign drop_count_o     = drop_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - directed self-checking bench for retire_trace_buffer
module tb_retire_trace_buffer;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            clear = 1'b0;
  logic [1:0]      update = '0;
  logic [1:0][31:0] pc = '0, instr = '0, reg_data = '0, mem_addr = '0, mem_data = '0;
  logic [1:0][4:0] reg_addr = '0;
  logic [1:0]      mem_wrt = '0;
  logic            trace_valid, trace_ready = 1'b0;
  logic [31:0]     trace_seq, trace_pc, trace_instr, trace_reg_data, trace_mem_addr, trace_mem_data;
  logic [4:0]      trace_reg_addr;
  logic            trace_mem_wrt;
  logic [4:0]      count;
  logic            overflow;
  logic [31:0]     drop_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  retire_trace_buffer dut (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear), .update_i(update),
    .pc_i(pc), .instr_i(instr), .reg_addr_i(reg_addr), .reg_data_i(reg_data),
    .mem_addr_i(mem_addr), .mem_data_i(mem_data), .mem_wrt_i(mem_wrt),
    .trace_valid_o(trace_valid), .trace_ready_i(trace_ready), .trace_seq_o(trace_seq),
    .trace_pc_o(trace_pc), .trace_instr_o(trace_instr), .trace_reg_addr_o(trace_reg_addr),
    .trace_reg_data_o(trace_reg_data), .trace_mem_addr_o(trace_mem_addr),
    .trace_mem_data_o(trace_mem_data), .trace_mem_wrt_o(trace_mem_wrt),
    .count_o(count), .overflow_o(overflow), .drop_count_o(drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic [31:0] p);
    pc[k]       = p;
    instr[k]    = ~p;
    reg_addr[k] = p[4:0];
    reg_data[k] = p + 32'd1;
    mem_addr[k] = p + 32'd2;
    mem_data[k] = p + 32'd3;
    mem_wrt[k]  = p[2];
  endtask

  task automatic push(input logic [1:0] u, input logic [31:0] p0, input logic [31:0] p1);
    set_lane(0, p0);
    set_lane(1, p1);
    update = u;
    tick();
    update = '0;
  endtask

  task automatic clr();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_pc", 64'(trace_pc), 64'd0);
    chk("rst_seq", 64'(trace_seq), 64'd0);
    rstn = 1'b1;
    tick();

    // 1: single lane-0 push
    push(2'b01, 32'h8000_0000, 32'h0);
    chk("t1_valid", 64'(trace_valid), 64'd1);
    chk("t1_pc", 64'(trace_pc), 64'h8000_0000);
    chk("t1_seq", 64'(trace_seq), 64'd0);
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_instr", 64'(trace_instr), 64'h7fff_ffff);
    chk("t1_reg_data", 64'(trace_reg_data), 64'h8000_0001);
    chk("t1_mem_data", 64'(trace_mem_data), 64'h8000_0003);
    chk("t1_mem_wrt", 64'(trace_mem_wrt), 64'd0);
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    chk("t1_drained", 64'(count), 64'd0);

    // 2: dual push drained in lane order
    clr();
    trace_ready = 1'b1;
    push(2'b11, 32'h100, 32'h104);
    chk("t2_count", 64'(count), 64'd2);
    chk("t2_pc0", 64'(trace_pc), 64'h100);
    chk("t2_seq0", 64'(trace_seq), 64'd0);
    tick();
    chk("t2_pc1", 64'(trace_pc), 64'h104);
    chk("t2_seq1", 64'(trace_seq), 64'd1);
    chk("t2_wrt1", 64'(trace_mem_wrt), 64'd1);
    tick();
    chk("t2_count_end", 64'(count), 64'd0);
    chk("t2_valid_end", 64'(trace_valid), 64'd0);
    trace_ready = 1'b0;

    // 3: lane-1-only push is compacted
    clr();
    push(2'b10, 32'h0, 32'h200);
    chk("t3_count", 64'(count), 64'd1);
    chk("t3_pc", 64'(trace_pc), 64'h200);
    chk("t3_seq", 64'(trace_seq), 64'd0);
    chk("t3_reg_addr", 64'(trace_reg_addr), 64'd0);
    chk("t3_mem_addr", 64'(trace_mem_addr), 64'h202);

    // 4: overflow is atomic and leaves gaps in the sequence
    clr();
    for (int i = 0; i < 7; i++) push(2'b11, 32'h1000 + 32'(8*i), 32'h1004 + 32'(8*i));
    push(2'b01, 32'h1038, 32'h0);
    chk("t4_fill", 64'(count), 64'd15);
    push(2'b11, 32'h2000, 32'h2004);
    chk("t4_count", 64'(count), 64'd15);
    chk("t4_overflow", 64'(overflow), 64'd1);
    chk("t4_drop", 64'(drop_count), 64'd2);
    chk("t4_head_pc", 64'(trace_pc), 64'h1000);
    push(2'b01, 32'h3000, 32'h0);
    chk("t4_full", 64'(count), 64'd16);
    push(2'b01, 32'h3004, 32'h0);
    chk("t4_full_drop", 64'(drop_count), 64'd3);
    chk("t4_full_count", 64'(count), 64'd16);
    trace_ready = 1'b1;
    repeat (15) tick();
    chk("t4_seq17", 64'(trace_seq), 64'd17);
    chk("t4_pc17", 64'(trace_pc), 64'h3000);
    chk("t4_count1", 64'(count), 64'd1);
    tick();
    chk("t4_empty", 64'(trace_valid), 64'd0);
    chk("t4_sticky", 64'(overflow), 64'd1);
    trace_ready = 1'b0;

    // 5: head stable under backpressure
    clr();
    push(2'b11, 32'h500, 32'h504);
    push(2'b01, 32'h508, 32'h0);
    chk("t5_count", 64'(count), 64'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_pc", 64'(trace_pc), 64'h500);
      chk("t5_hold_seq", 64'(trace_seq), 64'd0);
    end
    trace_ready = 1'b1;
    chk("t5_d0", 64'(trace_pc), 64'h500);
    tick();
    chk("t5_d1_pc", 64'(trace_pc), 64'h504);
    chk("t5_d1_seq", 64'(trace_seq), 64'd1);
    tick();
    chk("t5_d2_pc", 64'(trace_pc), 64'h508);
    chk("t5_d2_seq", 64'(trace_seq), 64'd2);
    tick();
    chk("t5_empty", 64'(trace_valid), 64'd0);
    trace_ready = 1'b0;

    // 6: clear beats a simultaneous push and pop
    for (int i = 0; i < 8; i++) push(2'b11, 32'h600 + 32'(8*i), 32'h604 + 32'(8*i));
    push(2'b11, 32'h680, 32'h684);
    chk("t6_overflow", 64'(overflow), 64'd1);
    chk("t6_drop", 64'(drop_count), 64'd2);
    chk("t6_head_seq", 64'(trace_seq), 64'd3);
    trace_ready = 1'b1;
    repeat (12) tick();
    chk("t6_count4", 64'(count), 64'd4);
    set_lane(0, 32'h690);
    set_lane(1, 32'h694);
    update = 2'b11;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    update = '0;
    trace_ready = 1'b0;
    chk("t6_clr_count", 64'(count), 64'd0);
    chk("t6_clr_valid", 64'(trace_valid), 64'd0);
    chk("t6_clr_overflow", 64'(overflow), 64'd0);
    chk("t6_clr_drop", 64'(drop_count), 64'd0);
    push(2'b01, 32'h700, 32'h0);
    chk("t6_seq0", 64'(trace_seq), 64'd0);
    chk("t6_pc", 64'(trace_pc), 64'h700);

    // asynchronous reset mid-stream
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_valid", 64'(trace_valid), 64'd0);
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_pc", 64'(trace_pc), 64'd0);
    rstn = 1'b1;
    tick();
    chk("ar_after", 64'(count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
